// File: rtl/mmio_register_bank_pkg.sv
// Shared memory-port encodings and lane helpers for the MMIO register bank.
package mmio_register_bank_pkg;

    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int MEM_COUNT_W = 2;
    localparam int MEM_CODE_W  = 2;
    localparam int MEM_LANE_W  = 4;

    typedef enum logic [MEM_COUNT_W-1:0] {
        MEM_COUNT_NONE = 2'd0,
        MEM_COUNT_BYTE = 2'd1,
        MEM_COUNT_HALF = 2'd2,
        MEM_COUNT_WORD = 2'd3
    } mem_count_e;

    typedef enum logic [MEM_CODE_W-1:0] {
        MEM_CODE_INVALID    = 2'd0,
        MEM_CODE_READ       = 2'd1,
        MEM_CODE_WRITE      = 2'd2,
        MEM_CODE_MISALIGNED = 2'd3
    } mem_code_e;

    function automatic logic [MEM_LANE_W-1:0] mem_lane_mask(input logic [MEM_COUNT_W-1:0] count,
                                                             input logic [1:0] lane);
        logic [MEM_LANE_W-1:0] m;
        case (count)
            MEM_COUNT_BYTE: m = 4'b0001 << lane;
            MEM_COUNT_HALF: m = 4'b0011 << lane;
            MEM_COUNT_WORD: m = 4'b1111;
            default:        m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic mem_misaligned(input logic [MEM_COUNT_W-1:0] count,
                                            input logic [1:0] lane);
        return ((count == MEM_COUNT_HALF) && lane[0]) ||
               ((count == MEM_COUNT_WORD) && (lane != 2'd0));
    endfunction

endpackage

// File: rtl/mmio_lane_align.sv
// Combinational lane steering: right-aligns read data and replicates write data across lanes.
module mmio_lane_align
    import mmio_register_bank_pkg::*;
(
    input  logic [WORD_W-1:0]      i_word,
    input  logic [WORD_W-1:0]      i_wr_data,
    input  logic [1:0]             i_lane,
    input  logic [MEM_COUNT_W-1:0] i_count,
    output logic [WORD_W-1:0]      o_rd_data,
    output logic [WORD_W-1:0]      o_wr_data,
    output logic [MEM_LANE_W-1:0]  o_lane_mask
);

    always_comb begin
        o_rd_data = '0;
        o_wr_data = i_wr_data;
        case (i_count)
            MEM_COUNT_BYTE: begin
                o_rd_data = {24'b0, i_word[{i_lane, 3'b000} +: 8]};
                o_wr_data = {4{i_wr_data[7:0]}};
            end
            MEM_COUNT_HALF: begin
                o_rd_data = {16'b0, i_word[{i_lane[1], 4'b0000} +: 16]};
                o_wr_data = {2{i_wr_data[15:0]}};
            end
            MEM_COUNT_WORD: o_rd_data = i_word;
            default: ;
        endcase
    end

    assign o_lane_mask = mem_lane_mask(i_count, i_lane);

endmodule

// File: rtl/mmio_register_bank.sv
// Byte/half/word MMIO access to a bank of RO, RW and write-1-to-clear registers.
module mmio_register_bank
    import mmio_register_bank_pkg::*;
#(
    parameter int                          WORD_COUNT  = 4,
    parameter logic [ADDR_W-1:0]           ADDR_START  = '0,
    parameter logic [WORD_COUNT-1:0]       RO_MASK     = '0,
    parameter logic [WORD_COUNT-1:0]       W1C_MASK    = '0,
    parameter logic [WORD_COUNT*WORD_W-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         areset,
    input  logic [WORD_COUNT*WORD_W-1:0] i_ro_values,
    input  logic [WORD_COUNT*WORD_W-1:0] i_set_bits,
    output logic [WORD_COUNT*WORD_W-1:0] o_registers,
    output logic [WORD_COUNT-1:0]        o_wr_strobe,
    input  logic [ADDR_W-1:0]            i_req_addr,
    input  logic [MEM_COUNT_W-1:0]       i_req_count,
    input  logic                         i_req_we,
    input  logic [WORD_W-1:0]            i_req_wr_data,
    output logic [WORD_W-1:0]            o_res_rd_data,
    output logic [MEM_CODE_W-1:0]        o_res_code
);

    localparam int IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int SLOTS = 2 ** IDX_W;
    localparam logic [SLOTS-1:0] RO_PAD = SLOTS'(RO_MASK);

    if ((RO_MASK & W1C_MASK) != '0) begin : g_mask_conflict
        $error("mmio_register_bank: a word is marked both RO and W1C");
    end

    logic [ADDR_W-1:0]           off;
    logic [1:0]                  lane;
    logic [ADDR_W-3:0]           idx_full;
    logic [IDX_W-1:0]            idx;
    logic                        in_range;
    logic [SLOTS-1:0][WORD_W-1:0] view;
    logic [WORD_W-1:0]           sel_word, al_rd, al_wr;
    logic [MEM_LANE_W-1:0]       lane_mask;
    logic                        wr_go;

    logic [WORD_W-1:0]     rd_q, rd_d;
    logic [MEM_CODE_W-1:0] code_q, code_d;
    logic [WORD_COUNT-1:0] stb_q, stb_d;

    assign off      = i_req_addr - ADDR_START;
    assign lane     = off[1:0];
    assign idx_full = off[ADDR_W-1:2];
    assign idx      = idx_full[IDX_W-1:0];
    assign in_range = (i_req_addr >= ADDR_START) && (idx_full < (ADDR_W-2)'(WORD_COUNT));
    assign sel_word = in_range ? view[idx] : '0;

    mmio_lane_align u_align (
        .i_word      (sel_word),
        .i_wr_data   (i_req_wr_data),
        .i_lane      (lane),
        .i_count     (i_req_count),
        .o_rd_data   (al_rd),
        .o_wr_data   (al_wr),
        .o_lane_mask (lane_mask)
    );

    always_comb begin
        code_d = MEM_CODE_INVALID;
        rd_d   = '0;
        wr_go  = 1'b0;
        if (mem_misaligned(i_req_count, lane)) begin
            code_d = MEM_CODE_MISALIGNED;
        end else if (!in_range || (i_req_count == MEM_COUNT_NONE)) begin
            code_d = MEM_CODE_INVALID;
        end else if (!i_req_we) begin
            code_d = MEM_CODE_READ;
            rd_d   = al_rd;
        end else if (!RO_PAD[idx]) begin
            code_d = MEM_CODE_WRITE;
            wr_go  = 1'b1;
        end
        stb_d = wr_go ? (WORD_COUNT'(1) << idx) : '0;
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_word
        if (i >= WORD_COUNT) begin : g_pad
            assign view[i] = '0;
        end else if (RO_MASK[i]) begin : g_ro
            logic unused_set;
            assign unused_set = ^i_set_bits[i*WORD_W +: WORD_W];
            assign view[i] = i_ro_values[i*WORD_W +: WORD_W];
            assign o_registers[i*WORD_W +: WORD_W] = '0;
        end else begin : g_store
            logic [WORD_W-1:0] reg_q, reg_d, bmask, set_bits;
            logic              hit;
            logic              unused_ro;
            assign unused_ro = ^i_ro_values[i*WORD_W +: WORD_W];
            assign hit       = wr_go && (idx == IDX_W'(i));
            assign bmask     = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
            // Set is applied after the clear so a simultaneous set wins.
            assign set_bits  = W1C_MASK[i] ? i_set_bits[i*WORD_W +: WORD_W] : '0;

            always_comb begin
                reg_d = reg_q;
                if (W1C_MASK[i]) begin
                    if (hit) reg_d = reg_q & ~(al_wr & bmask);
                    reg_d = reg_d | set_bits;
                end else if (hit) begin
                    reg_d = (reg_q & ~bmask) | (al_wr & bmask);
                end
            end

            always_ff @(posedge clk or posedge areset) begin
                if (areset) reg_q <= RESET_VALUE[i*WORD_W +: WORD_W];
                else        reg_q <= reg_d;
            end

            assign view[i] = reg_q;
            assign o_registers[i*WORD_W +: WORD_W] = reg_q;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rd_q   <= '0;
            code_q <= MEM_CODE_INVALID;
            stb_q  <= '0;
        end else begin
            rd_q   <= rd_d;
            code_q <= code_d;
            stb_q  <= stb_d;
        end
    end

    assign o_res_rd_data = rd_q;
    assign o_res_code    = code_q;
    assign o_wr_strobe   = stb_q;

endmodule

// File: tb/tb_mmio_register_bank.sv
// Scoreboard bench: stimulus queues expected responses, a monitor checks them one cycle later.
module tb_mmio_register_bank;
    import mmio_register_bank_pkg::*;

    localparam int WC = 4;
    localparam logic [WC*32-1:0] RV = {32'h0, 32'h0, 32'hA5A5_0000, 32'h0};

    logic            clk = 1'b0;
    logic            areset;
    logic [WC*32-1:0] i_ro_values, i_set_bits, o_registers;
    logic [WC-1:0]   o_wr_strobe;
    logic [31:0]     i_req_addr, i_req_wr_data, o_res_rd_data;
    logic [1:0]      i_req_count, o_res_code;
    logic            i_req_we;

    mmio_register_bank #(
        .WORD_COUNT (WC),
        .ADDR_START (32'h40),
        .RO_MASK    (4'b0100),
        .W1C_MASK   (4'b1000),
        .RESET_VALUE(RV)
    ) dut (
        .clk          (clk),
        .areset       (areset),
        .i_ro_values  (i_ro_values),
        .i_set_bits   (i_set_bits),
        .o_registers  (o_registers),
        .o_wr_strobe  (o_wr_strobe),
        .i_req_addr   (i_req_addr),
        .i_req_count  (i_req_count),
        .i_req_we     (i_req_we),
        .i_req_wr_data(i_req_wr_data),
        .o_res_rd_data(o_res_rd_data),
        .o_res_code   (o_res_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic [1:0]  code;
        logic [3:0]  stb;
        bit          chk;
        int          ridx;
        logic [31:0] rval;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic issue(input string n, input logic [1:0] cnt, input logic [31:0] addr,
                         input logic we, input logic [31:0] wd, input logic [31:0] set3,
                         input logic [31:0] erd, input logic [1:0] ecode, input logic [3:0] estb,
                         input bit chk, input int ridx, input logic [31:0] rval);
        exp_t e;
        @(negedge clk);
        i_req_count   = cnt;
        i_req_addr    = addr;
        i_req_we      = we;
        i_req_wr_data = wd;
        i_set_bits    = {set3, 96'h0};
        e.name = n; e.rd = erd; e.code = ecode; e.stb = estb;
        e.chk = chk; e.ridx = ridx; e.rval = rval;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".rd"},   o_res_rd_data, e.rd);
                check({e.name, ".code"}, {30'b0, o_res_code}, {30'b0, e.code});
                check({e.name, ".stb"},  {28'b0, o_wr_strobe}, {28'b0, e.stb});
                if (e.chk) check({e.name, ".reg"}, o_registers[e.ridx*32 +: 32], e.rval);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        areset        = 1'b1;
        i_ro_values   = {32'h0, 32'h1234_5678, 64'h0};
        i_set_bits    = '0;
        i_req_addr    = '0;
        i_req_count   = MEM_COUNT_NONE;
        i_req_we      = 1'b0;
        i_req_wr_data = '0;
        #3;
        check("rst.code", {30'b0, o_res_code}, 32'(MEM_CODE_INVALID));
        check("rst.rd",   o_res_rd_data, 32'h0);
        check("rst.stb",  {28'b0, o_wr_strobe}, 32'h0);
        check("rst.reg1", o_registers[63:32], 32'hA5A5_0000);
        @(negedge clk);
        areset = 1'b0;

        issue("rd_w1_rv",   MEM_COUNT_WORD, 32'h44, 0, 0, 0, 32'hA5A5_0000, MEM_CODE_READ,  4'b0000, 0, 0, 0);
        issue("wr_b_w0",    MEM_COUNT_BYTE, 32'h42, 1, 32'h7E, 0, 0, MEM_CODE_WRITE, 4'b0001, 1, 0, 32'h007E_0000);
        issue("rd_w0",      MEM_COUNT_WORD, 32'h40, 0, 0, 0, 32'h007E_0000, MEM_CODE_READ,  4'b0000, 1, 0, 32'h007E_0000);
        issue("wr_h_w1",    MEM_COUNT_HALF, 32'h44, 1, 32'h1234, 0, 0, MEM_CODE_WRITE, 4'b0010, 1, 1, 32'hA5A5_1234);
        issue("rd_b_w1_l3", MEM_COUNT_BYTE, 32'h47, 0, 0, 0, 32'h0000_00A5, MEM_CODE_READ,  4'b0000, 0, 0, 0);
        issue("rd_b_w1_l1", MEM_COUNT_BYTE, 32'h45, 0, 0, 0, 32'h0000_0012, MEM_CODE_READ,  4'b0000, 0, 0, 0);
        issue("rd_h_ro",    MEM_COUNT_HALF, 32'h4A, 0, 0, 0, 32'h0000_1234, MEM_CODE_READ,  4'b0000, 1, 2, 32'h0);
        issue("wr_ro",      MEM_COUNT_WORD, 32'h48, 1, 0, 0, 32'h0, MEM_CODE_INVALID, 4'b0000, 1, 2, 32'h0);
        issue("rd_w_ro",    MEM_COUNT_WORD, 32'h48, 0, 0, 0, 32'h1234_5678, MEM_CODE_READ,  4'b0000, 0, 0, 0);
        issue("set_w3",     MEM_COUNT_NONE, 32'h40, 0, 0, 32'hF0, 32'h0, MEM_CODE_INVALID, 4'b0000, 1, 3, 32'h0000_00F0);
        issue("wr_w1c",     MEM_COUNT_WORD, 32'h4C, 1, 32'h30, 32'h10, 32'h0, MEM_CODE_WRITE, 4'b1000, 1, 3, 32'h0000_00D0);
        issue("rd_w1c_set", MEM_COUNT_WORD, 32'h4C, 0, 0, 32'h100, 32'h0000_00D0, MEM_CODE_READ, 4'b0000, 1, 3, 32'h0000_01D0);
        issue("rd_w1c",     MEM_COUNT_WORD, 32'h4C, 0, 0, 0, 32'h0000_01D0, MEM_CODE_READ, 4'b0000, 0, 0, 0);
        issue("mis_half",   MEM_COUNT_HALF, 32'h41, 0, 0, 0, 32'h0, MEM_CODE_MISALIGNED, 4'b0000, 0, 0, 0);
        issue("mis_wr",     MEM_COUNT_WORD, 32'h42, 1, 32'hFFFF_FFFF, 0, 32'h0, MEM_CODE_MISALIGNED, 4'b0000, 1, 0, 32'h007E_0000);
        issue("oob_hi_wr",  MEM_COUNT_WORD, 32'h50, 1, 32'hFFFF_FFFF, 0, 32'h0, MEM_CODE_INVALID, 4'b0000, 1, 0, 32'h007E_0000);
        issue("oob_lo",     MEM_COUNT_BYTE, 32'h3C, 0, 0, 0, 32'h0, MEM_CODE_INVALID, 4'b0000, 0, 0, 0);
        issue("oob_lo_wr",  MEM_COUNT_WORD, 32'h3C, 1, 32'hFFFF_FFFF, 0, 32'h0, MEM_CODE_INVALID, 4'b0000, 1, 3, 32'h0000_01D0);
        issue("none_wr",    MEM_COUNT_NONE, 32'h40, 1, 32'hFFFF_FFFF, 0, 32'h0, MEM_CODE_INVALID, 4'b0000, 1, 0, 32'h007E_0000);
        issue("rd_w0_last", MEM_COUNT_WORD, 32'h40, 0, 0, 0, 32'h007E_0000, MEM_CODE_READ, 4'b0000, 0, 0, 0);

        // Reset lands between request setup and its clock edge.
        @(negedge clk);
        i_req_count   = MEM_COUNT_WORD;
        i_req_addr    = 32'h40;
        i_req_we      = 1'b1;
        i_req_wr_data = 32'hFFFF_FFFF;
        i_set_bits    = '0;
        #2;
        areset = 1'b1;
        #1;
        check("arst.code", {30'b0, o_res_code}, 32'(MEM_CODE_INVALID));
        check("arst.rd",   o_res_rd_data, 32'h0);
        check("arst.stb",  {28'b0, o_wr_strobe}, 32'h0);
        check("arst.reg0", o_registers[31:0], 32'h0);
        check("arst.reg1", o_registers[63:32], 32'hA5A5_0000);
        check("arst.reg3", o_registers[127:96], 32'h0);
        @(posedge clk);
        #1;
        check("arst_edge.reg0", o_registers[31:0], 32'h0);
        check("arst_edge.code", {30'b0, o_res_code}, 32'(MEM_CODE_INVALID));
        @(negedge clk);
        areset      = 1'b0;
        i_req_count = MEM_COUNT_NONE;

        issue("post_rst_w0", MEM_COUNT_WORD, 32'h40, 0, 0, 0, 32'h0, MEM_CODE_READ, 4'b0000, 1, 0, 32'h0);
        issue("post_rst_w1", MEM_COUNT_WORD, 32'h44, 0, 0, 0, 32'hA5A5_0000, MEM_CODE_READ, 4'b0000, 0, 0, 0);
        issue("idle",        MEM_COUNT_NONE, 32'h0, 0, 0, 0, 32'h0, MEM_CODE_INVALID, 4'b0000, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
